// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector stimulus controller:
// state encoding, default sizing and the pattern-length legality check.
package seq_pkg;

    localparam int SEQ_MAXLEN = 32;
    localparam int SEQ_CNTW   = 8;
    localparam int SEQ_FLUSH  = 6;
    localparam int SEQ_CLRCYC = 2;

    // Width of the CLEAR and DRAIN cycle counters; covers FLUSH/CLRCYC up to 8.
    localparam int SEQ_CTRW   = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic logic len_ok(input logic [5:0] l, input int maxlen);
        return (l != 6'd0) && (int'(l) <= maxlen);
    endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating hit counter: synchronous clear has priority over enable,
// and the count sticks at all-ones instead of wrapping.
module seq_hit_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_stim_ctrl.sv
// Host-controlled stimulus sequencer for the serial sequence detector:
// clear detector, stream a latched pattern reps times MSB-first, flush, report.
//
// Handshake: start is a single-cycle request honoured only in IDLE; an illegal
// start yields a one-cycle err, a legal one raises busy until after the done
// pulse. abort cancels CLEAR/RUN/DRAIN; it never suppresses an imminent DONE.
module seq_stim_ctrl
    import seq_pkg::*;
#(
    parameter int MAXLEN = SEQ_MAXLEN,
    parameter int CNTW   = SEQ_CNTW,
    parameter int FLUSH  = SEQ_FLUSH,
    parameter int CLRCYC = SEQ_CLRCYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [5:0]        len,
    input  logic [CNTW-1:0]   reps,
    input  logic              abort,
    output logic              din,
    output logic              det_rst_n,
    input  logic              dout,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNTW-1:0]   hit_cnt,
    output logic [5:0]        bit_idx,
    output logic [2:0]        state_dbg
);

    localparam logic [SEQ_CTRW-1:0] CLR_LAST   = SEQ_CTRW'(CLRCYC - 1);
    localparam logic [SEQ_CTRW-1:0] FLUSH_LAST = SEQ_CTRW'(FLUSH - 1);

    state_e              state_q, state_d;
    logic [MAXLEN-1:0]   pat_q, pat_d;
    logic [5:0]          len_q, len_d;
    logic [CNTW-1:0]     reps_q, reps_d;
    logic [CNTW-1:0]     rep_q, rep_d;
    logic [5:0]          idx_q, idx_d;
    logic [SEQ_CTRW-1:0] clr_q, clr_d;
    logic [SEQ_CTRW-1:0] fl_q, fl_d;
    logic                din_q, din_d;
    logic                rstn_q, rstn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hit_clr;
    logic                hit_en;
    logic [5:0]          sel_amt;
    logic [MAXLEN-1:0]   sel_mask;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        reps_d   = reps_q;
        rep_d    = rep_q;
        idx_d    = idx_q;
        clr_d    = clr_q;
        fl_d     = fl_q;
        err_d    = 1'b0;
        hit_clr  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok(len, MAXLEN) && (reps != '0)) begin
                        state_d = S_CLEAR;
                        pat_d   = pattern;
                        len_d   = len;
                        reps_d  = reps;
                        clr_d   = '0;
                        hit_clr = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (clr_q == CLR_LAST) begin
                    state_d = S_RUN;
                    idx_d   = 6'd0;
                    rep_d   = reps_q;
                end else begin
                    clr_d = clr_q + SEQ_CTRW'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q == len_q - 6'd1) begin
                    idx_d = 6'd0;
                    if (rep_q == CNTW'(1)) begin
                        state_d = S_DRAIN;
                        fl_d    = '0;
                    end else begin
                        rep_d = rep_q - CNTW'(1);
                    end
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_DRAIN: begin
                // The last flush cycle commits to DONE even if abort arrives with it.
                if (fl_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end else if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    fl_d = fl_q + SEQ_CTRW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != S_RUN) begin
            idx_d = 6'd0;
        end

        // Outputs are registered, so derive them from the state being entered.
        sel_amt  = len_d - 6'd1 - idx_d;
        sel_mask = {{(MAXLEN-1){1'b0}}, 1'b1} << sel_amt;
        din_d    = (state_d == S_RUN) && (|(pat_d & sel_mask));
        rstn_d   = (state_d != S_CLEAR);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            reps_q  <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            clr_q   <= '0;
            fl_q    <= '0;
            din_q   <= 1'b0;
            rstn_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            reps_q  <= reps_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            clr_q   <= clr_d;
            fl_q    <= fl_d;
            din_q   <= din_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign hit_en = dout && ((state_q == S_RUN) || (state_q == S_DRAIN));

    seq_hit_counter #(
        .W (CNTW)
    ) u_hits (
        .clk   (clk),
        .rst   (rst),
        .clr_i (hit_clr),
        .en_i  (hit_en),
        .cnt_o (hit_cnt)
    );

    assign din       = din_q;
    assign det_rst_n = rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bit_idx   = idx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Directed bench for seq_stim_ctrl: a table of runs with hand-computed
// busy length, done/err counts and hit totals, plus reset corner sequences.
module tb_seq_stim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pattern;
    logic [5:0]  len;
    logic [7:0]  reps;
    logic        abort;
    logic        din;
    logic        det_rst_n;
    logic        dout;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  hit_cnt;
    logic [5:0]  bit_idx;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // abort_at: cycle index (0 = first cycle after the start edge) to raise abort,
    // -2 raises abort together with start, -1 never. start_at re-pulses start.
    typedef struct {
        string       name;
        logic [31:0] pattern;
        logic [5:0]  len;
        logic [7:0]  reps;
        logic        tie;
        logic [63:0] mask;
        int          abort_at;
        int          start_at;
        int          exp_err;
        int          exp_busy;
        int          exp_done;
        int          exp_hits;
    } vec_t;

    vec_t vt [13];

    logic       din_a  [0:399];
    logic       rstn_a [0:399];
    logic       busy_a [0:399];
    logic       done_a [0:399];
    logic       err_a  [0:399];
    logic [5:0] idx_a  [0:399];

    always #5 clk = ~clk;

    seq_stim_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .reps      (reps),
        .abort     (abort),
        .din       (din),
        .det_rst_n (det_rst_n),
        .dout      (dout),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .hit_cnt   (hit_cnt),
        .bit_idx   (bit_idx),
        .state_dbg (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " din"},       {31'd0, din},       32'd0);
        check({tag, " det_rst_n"}, {31'd0, det_rst_n}, 32'd0);
        check({tag, " busy"},      {31'd0, busy},      32'd0);
        check({tag, " done"},      {31'd0, done},      32'd0);
        check({tag, " err"},       {31'd0, err},       32'd0);
        check({tag, " hit_cnt"},   {24'd0, hit_cnt},   32'd0);
        check({tag, " bit_idx"},   {26'd0, bit_idx},   32'd0);
        check({tag, " state"},     {29'd0, state_dbg}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int   ncyc;
        bit   ended;
        int   nb, nd, ne, bad, first_bad;
        int   lv, j;
        logic ed, er;
        logic [5:0] ei;

        pattern = v.pattern;
        len     = v.len;
        reps    = v.reps;
        start   = 1'b1;
        abort   = (v.abort_at == -2);
        dout    = v.tie;
        tick();
        start = 1'b0;
        abort = 1'b0;

        ncyc  = 0;
        ended = 1'b0;
        for (int i = 0; i < 400 && !ended; i++) begin
            din_a[i]  = din;
            rstn_a[i] = det_rst_n;
            busy_a[i] = busy;
            done_a[i] = done;
            err_a[i]  = err;
            idx_a[i]  = bit_idx;
            if (i > 0 && !busy) begin
                ncyc  = i;
                ended = 1'b1;
            end else begin
                dout  = v.tie | ((i < 64) ? v.mask[i] : 1'b0);
                abort = (i == v.abort_at);
                if (i == v.start_at) begin
                    start = 1'b1;
                    len   = 6'd0;
                end else begin
                    start = 1'b0;
                end
                tick();
            end
        end
        dout  = 1'b0;
        abort = 1'b0;
        start = 1'b0;

        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy still high after 400 cycles", v.name);
            return;
        end

        nb = 0;
        nd = 0;
        ne = 0;
        for (int k = 0; k <= ncyc; k++) begin
            nb += int'(busy_a[k]);
            nd += int'(done_a[k]);
            ne += int'(err_a[k]);
        end
        check({v.name, " busy_cycles"}, nb, v.exp_busy);
        check({v.name, " done_pulses"}, nd, v.exp_done);
        check({v.name, " err_pulses"},  ne, v.exp_err);
        if (v.exp_done != 0) begin
            check({v.name, " done_last_busy"}, {31'd0, done_a[v.exp_busy-1]}, 32'd1);
        end

        lv        = int'(v.len);
        bad       = 0;
        first_bad = -1;
        for (int k = 0; k <= ncyc; k++) begin
            if (v.exp_err != 0 || k == ncyc) begin
                ed = 1'b0; er = 1'b1; ei = 6'd0;
            end else if (k < 2) begin
                ed = 1'b0; er = 1'b0; ei = 6'd0;
            end else if (k < 2 + lv * int'(v.reps)) begin
                j  = (k - 2) % lv;
                ed = v.pattern[lv-1-j];
                er = 1'b1;
                ei = 6'(j);
            end else begin
                ed = 1'b0; er = 1'b1; ei = 6'd0;
            end
            if (din_a[k] !== ed || rstn_a[k] !== er || idx_a[k] !== ei) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        check({v.name, " stream_mismatches"}, bad, 0);
        if (bad != 0) $display("  first differing cycle %0d in %s", first_bad, v.name);
        check({v.name, " hit_cnt"}, {24'd0, hit_cnt}, v.exp_hits);
    endtask

    initial begin
        //          name                pattern        len    reps  tie   mask                    abort start err busy done hits
        vt[0]  = '{"basic",            32'h0000002B, 6'd6,  8'd2,  1'b0, 64'h0,                  -1,   -1,   0,  21,  1,   0};
        vt[1]  = '{"hits4",            32'h0000002B, 6'd6,  8'd2,  1'b0, 64'h0000_0000_0011_00A9, -1,  -1,   0,  21,  1,   4};
        vt[2]  = '{"len32_sat",        32'hA5C30F96, 6'd32, 8'd10, 1'b1, 64'h0,                  -1,   -1,   0,  329, 1,   255};
        vt[3]  = '{"len1",             32'h00000001, 6'd1,  8'd3,  1'b0, 64'h14,                 -1,   -1,   0,  12,  1,   2};
        vt[4]  = '{"rej_len0",         32'h0000002B, 6'd0,  8'd2,  1'b0, 64'h0,                  -1,   -1,   1,  0,   0,   2};
        vt[5]  = '{"rej_reps0",        32'h0000002B, 6'd6,  8'd0,  1'b0, 64'h0,                  -1,   -1,   1,  0,   0,   2};
        vt[6]  = '{"rej_len33",        32'h0000002B, 6'd33, 8'd1,  1'b0, 64'h0,                  -1,   -1,   1,  0,   0,   2};
        vt[7]  = '{"start_while_busy", 32'h0000002B, 6'd6,  8'd2,  1'b0, 64'h0,                  -1,   5,    0,  21,  1,   0};
        vt[8]  = '{"abort_run5",       32'h0000002B, 6'd6,  8'd2,  1'b1, 64'h0,                  6,    -1,   0,  7,   0,   5};
        vt[9]  = '{"abort_clear",      32'h0000002B, 6'd6,  8'd2,  1'b1, 64'h0,                  0,    -1,   0,  1,   0,   0};
        vt[10] = '{"abort_at_done_in", 32'h00000013, 6'd5,  8'd3,  1'b0, 64'h0,                  22,   -1,   0,  24,  1,   0};
        vt[11] = '{"abort_in_done",    32'h00000013, 6'd5,  8'd3,  1'b0, 64'h0,                  23,   -1,   0,  24,  1,   0};
        vt[12] = '{"start_abort_idle", 32'h00000006, 6'd3,  8'd2,  1'b1, 64'h0,                  -2,   -1,   0,  15,  1,   12};

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        dout    = 1'b0;
        pattern = 32'd0;
        len     = 6'd0;
        reps    = 8'd0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle det_rst_n", {31'd0, det_rst_n}, 32'd1);
        check("idle busy", {31'd0, busy}, 32'd0);

        for (int n = 0; n < 13; n++) begin
            run_vec(vt[n]);
            tick();
        end

        // Asynchronous reset in the middle of a run, between clock edges.
        pattern = 32'h0000002B;
        len     = 6'd6;
        reps    = 8'd2;
        dout    = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_reset din", {31'd0, din}, 32'd1);
        check("pre_reset bit_idx", {26'd0, bit_idx}, 32'd2);
        check("pre_reset hit_cnt", {24'd0, hit_cnt}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun");
        #2;
        rst  = 1'b0;
        dout = 1'b0;
        tick();
        check("post_reset det_rst_n", {31'd0, det_rst_n}, 32'd1);
        check("post_reset busy", {31'd0, busy}, 32'd0);
        run_vec(vt[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
